clock_key_ctrl: RTL
===================

// Module: clock_key_ctrl
// PURPOSE
//  Front-end controller for the hh:mm:ss clock counters: synchronises and debounces 4 raw push keys.
//  Runs the SET/RUN mode FSM and issues single-cycle increment strobes (hour/min/sec) in SET mode.
//  Issues a 1 Hz seconds tick in RUN mode. The counter datapath consumes only these strobes.
// PARAMETERS
//  DEB_CYCLES  1_000_000   cycles a synchronised key level must be stable before acceptance (20 ms @ 50 MHz)
//  TICK_DIV    50_000_000  clk cycles per sec_tick in RUN
//  REP_DELAY   25_000_000  hold time before auto-repeat starts (KEY_REPEAT_EN only)
//  REP_PERIOD  5_000_000   auto-repeat strobe interval (KEY_REPEAT_EN only)
// PORTS
//  clk       in   1  system clock
//  rst       in   1  asynchronous, active-low reset
//  key_n     in   4  raw keys, active-low, asynchronous; [3]=mode, [2]=sec, [1]=min, [0]=hour
//  run       out  1  1=RUN (time advancing), 0=SET
//  sec_tick  out  1  one-cycle strobe, advance seconds (RUN only)
//  inc_sec   out  1  one-cycle strobe, +1 second (SET only)
//  inc_min   out  1  one-cycle strobe, +1 minute (SET only)
//  inc_hour  out  1  one-cycle strobe, +1 hour (SET only)
// BEHAVIOUR
//  Reset: clk is the clock; rst is asynchronous, active-low.
//   - Asserting rst at any time, including mid-debounce or mid-tick, clears everything at once.
//   - Reset state: sync FFs=1, debounced state=released(1), all counters=0, run=0 (SET), all strobes=0.
//   - A key held through reset release yields exactly one press after debounce.
//  Sync: 2-FF synchroniser per key; s2 = key_n delayed 2 edges.
//  Debounce, per key, independent:
//   - cnt increments while s2!=deb; cnt clears whenever s2==deb.
//   - When cnt==DEB_CYCLES-1 and s2!=deb: deb<=s2, cnt<=0.
//   - deb 1->0 sets internal press[i] for exactly one cycle; 0->1 (release) makes no pulse.
//   - Latency: first edge sampling key_n low = edge 1; press[i] high after edge DEB_CYCLES+2.
//   - Any bounce shorter than DEB_CYCLES cycles produces no press and no release.
//  Mode FSM, 2 states, registered; output edge = edge after press:
//   - SET --press[3]--> RUN;  RUN --press[3]--> SET.
//   - run, inc_* update on the same edge.
//  Strobes: inc_sec/min/hour <= press[2]/[1]/[0] & !run & !press[3] (registered).
//   - Presses in RUN are discarded; a press coincident with the mode press is discarded.
//   - Several adjust keys pressed in the same cycle: all corresponding strobes fire together.
//  Prescaler (clog2(TICK_DIV) bits):
//   - Held at 0 while run=0; counts 0..TICK_DIV-1 and wraps while run=1.
//   - sec_tick <= (pre==TICK_DIV-1) & run.
//   - First sec_tick exactly TICK_DIV cycles after run rises, then period TICK_DIV.
//   - Leaving RUN clears pre; a partial second is lost; no sec_tick in the cycle run falls.
//  At most one strobe type is active per mode: sec_tick never coincides with an inc_* strobe.
// CONFIGURATION
//  KEY_REPEAT_EN defined: auto-repeat on keys [2:0] in SET only.
//   - A key still debounced-pressed REP_DELAY cycles after its press pulse re-issues its inc_* strobe.
//   - Repeat strobes then follow every REP_PERIOD cycles until release or a mode change.
//   - One repeat timer per key; key[3] never repeats.
//  KEY_REPEAT_EN undefined: exactly one strobe per press; no repeat logic or timers synthesised.
// TESTING  (DEB_CYCLES=4, TICK_DIV=10, REP_DELAY=20, REP_PERIOD=5)
//  1. rst low mid-count, keys released -> run=0, all strobes 0, sec_tick never asserts while run=0.
//  2. key_n[2] low for 3 cycles, then high (glitch) -> no inc_sec.
//     key_n[2] held low 20 cycles -> one inc_sec at edge 7 (DEB_CYCLES+3) after first low sample.
//  3. Press key_n[3] -> run=1 at edge 7; sec_tick at edges 17, 27, 37; adjust keys in RUN give no inc_*.
//  4. In RUN, press key_n[3] together with key_n[0] -> run=0, inc_hour stays 0, prescaler reads 0.
//  5. In SET, press key_n[1] and key_n[0] in the same cycle -> inc_min and inc_hour high on the same cycle, once.
//  6. KEY_REPEAT_EN, SET, key_n[2] held 50 cycles -> inc_sec at the press, then after +20, +25, +30... until release; none after release.
//     Without KEY_REPEAT_EN, same stimulus -> exactly one inc_sec.

Source files
------------

// File: rtl/clock_key_ctrl.sv
// clock_key_ctrl: key sync/debounce, SET/RUN mode FSM, inc strobes, 1 Hz tick.
// Optional auto-repeat on adjust keys [2:0] in SET: define KEY_REPEAT_EN.
module clock_key_ctrl #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int TICK_DIV   = 50_000_000,
  parameter int REP_DELAY  = 25_000_000,
  parameter int REP_PERIOD = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  output logic       run,
  output logic       sec_tick,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {
    S_SET = 1'b0,
    S_RUN = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic [3:0]    r_deb;
  logic [3:0]    r_press;
  logic [DW-1:0] r_cnt [4];
  logic [3:0]    w_fall;
  logic [PW-1:0] r_pre;
  logic          r_tick;
  logic [2:0]    r_inc;
  logic [2:0]    w_rep;

  assign run      = (r_state == S_RUN);
  assign sec_tick = r_tick;
  assign inc_sec  = r_inc[2];
  assign inc_min  = r_inc[1];
  assign inc_hour = r_inc[0];

  // two-flop synchroniser, idles at released level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= key_n;
      r_s2 <= r_s1;
    end
  end

  // debounced level about to fall: accepted press this edge
  always_comb begin
    w_fall = '0;
    for (int i = 0; i < 4; i++) begin
      w_fall[i] = (r_s2[i] != r_deb[i]) &&
                  (r_cnt[i] == DEB_MAX) &&
                  !r_s2[i];
    end
  end

  // per-key stability counters and press pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb   <= '1;
      r_press <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_press <= w_fall;
      for (int i = 0; i < 4; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_MAX) begin
          r_deb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // mode state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_SET;
    else      r_state <= w_state_nxt;
  end

  // mode key toggles SET/RUN
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_SET: if (r_press[3]) w_state_nxt = S_RUN;
      S_RUN: if (r_press[3]) w_state_nxt = S_SET;
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = (REP_DELAY > 1) ? $clog2(REP_DELAY) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] REP_LOAD = RW'(REP_DELAY - REP_PERIOD);

  logic [RW-1:0] r_rtm [3];
  logic [2:0]    r_arm;
  logic [2:0]    r_rep;

  // hold timers: first repeat after REP_DELAY, then every REP_PERIOD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_arm <= '0;
      r_rep <= '0;
      for (int i = 0; i < 3; i++) r_rtm[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_rep[i] <= 1'b0;
        if (w_fall[i] && !run) begin
          r_arm[i] <= 1'b1;
          r_rtm[i] <= '0;
        end else if (r_deb[i] || run || r_press[3]) begin
          r_arm[i] <= 1'b0;
        end else if (r_arm[i]) begin
          if (r_rtm[i] == REP_LAST) begin
            r_rep[i] <= 1'b1;
            r_rtm[i] <= REP_LOAD;
          end else begin
            r_rtm[i] <= r_rtm[i] + 1'b1;
          end
        end
      end
    end
  end

  assign w_rep = r_rep;
`else
  assign w_rep = '0;
`endif

  // adjust strobes only in SET, never alongside a mode change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_inc <= '0;
    else      r_inc <= (r_press[2:0] | w_rep) &
                       {3{!run && !r_press[3]}};
  end

  // seconds prescaler, cleared outside RUN and on leaving RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= run && !r_press[3] && (r_pre == PRE_MAX);
      if (!run || r_press[3] || (r_pre == PRE_MAX))
        r_pre <= '0;
      else
        r_pre <= r_pre + 1'b1;
    end
  end

endmodule
